heart_render: RTL and testbench
===============================

# heart_render

Raster-side sprite stage that consumes the heart position (`x_scr`, `y_scr`), pixel scale (`wpixel`, `hpixel`) and `show` produced by the heart dynamics block. It turns the VGA sync generator's scan coordinates into addresses for the 100×92 monochrome heart ROM and returns the per-pixel on/off decision to the colour mux. Scaling uses incremental counters only, with no multipliers or dividers. Sprite parameters are latched once per frame so that a beat or size change never tears the image mid-frame.

## Interface
Parameters:
- `WIDTH_ROM`, default 100: sprite width in ROM pixels.
- `HEIGHT_ROM`, default 92: sprite height in ROM pixels.
- `ADDR_W`, default 14: ROM address width (must satisfy 2^ADDR_W ≥ WIDTH_ROM·HEIGHT_ROM).

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `x_px`  in  10  current scan column (raster order, +1 per active cycle).
- `y_px`  in  10  current scan line.
- `activevideo`  in  1  high during visible 640×480 area.
- `x_scr`  in  10  sprite left edge.
- `y_scr`  in  10  sprite top edge.
- `wpixel`  in  4  horizontal scale (screen pixels per ROM pixel).
- `hpixel`  in  4  vertical scale.
- `show`  in  1  sprite enable.
- `rom_addr`  out  ADDR_W  synchronous ROM address (1-cycle read).
- `rom_data`  in  1  ROM bit for the address presented on the previous cycle.
- `pixel_on`  out  1  heart pixel lit, aligned with `valid`.
- `valid`  out  1  `activevideo` delayed to match `pixel_on`.

## Operation
- **Frame latch.** On an active cycle with `x_px==0` and `y_px==0`, latch `x_scr`, `y_scr`, `wpixel`, `hpixel` and `show` into `xs_l`, `ys_l`, `w_l`, `h_l`, `show_l`. A scale of 0 is latched as 1. Latched values are used for the whole frame.
- **Horizontal counters (per active cycle).**
  - At `x_px==xs_l`: set `in_x`=1, `col`=0, `subx`=0.
  - While `in_x`: increment `subx`. When `subx==w_l-1`, clear `subx` and increment `col`.
  - When `col==WIDTH_ROM-1` and `subx==w_l-1`: clear `in_x` after the current pixel.
  - On the falling edge of `activevideo`: clear `in_x` (sprite clipped at the right screen edge).
- **Vertical counters (at each line end, i.e. `activevideo` falling edge).**
  - If `y_px+1==ys_l`: arm `in_y`, `row`=0, `suby`=0, `rowbase`=0.
  - Else while `in_y`: `suby` advances modulo `h_l`. On wrap, `row`+1 and `rowbase`+=WIDTH_ROM.
  - After `row==HEIGHT_ROM-1` wraps: clear `in_y`.
  - `ys_l==0` is armed directly at frame latch.
- **Hit and address.** `hit = activevideo & in_x & in_y` for the current pixel. `rom_addr = rowbase + col`, registered. `rom_addr` holds its last value when not hit.
- **Out-of-range position.** If `xs_l`≥640 or `ys_l`≥480 (e.g. an underflowed centre position from an oversized scale), there is no hit all frame.
- **Output.** `pixel_on = hit_d2 & show_l_d2 & rom_data`, where `hit_d2` is `hit` delayed two cycles and `show_l_d2` is `show_l` delayed the same way.
- **Reset values.** All counters, latches and outputs are 0, except `w_l`=`h_l`=1.
- **Reset mid-frame.** Outputs go to 0 immediately. `show_l`=0 holds until the next frame latch, so no partial sprite is drawn.

## Timing
- Latency is 2 clk from `x_px`/`y_px`/`activevideo` to `pixel_on`/`valid`:
  - Cycle 0: the scan coordinate is presented.
  - Cycle 1: `rom_addr` is valid.
  - Cycle 2: `rom_data` is returned and `pixel_on` is registered.
- `valid` equals `activevideo` delayed 2 clk.
- Frame latch takes effect for pixel (0,0) itself. Changes on `x_scr`, `y_scr`, `wpixel`, `hpixel` or `show` at any other time become visible only at the next frame.
- Counters advance only on active cycles. Blanking does not disturb horizontal state except the line-end clear.
- Sprite width on screen is WIDTH_ROM·w_l, truncated at column 639. Height is HEIGHT_ROM·h_l, truncated at line 479.

## Test plan
- **Basic scan.** x_scr=170, y_scr=102, w=h=3, show=1, full frame.
  - `rom_addr`: 0 for (170..172,102); 1 at (173,102); 99 at (467..469,102); 100 at (170,105); 9199 at (469,377).
  - No hit at (169,102), (470,102) or (170,378).
- **Latency and data.** ROM model returns bit = addr[0]. `pixel_on` at cycle k+2 equals `rom_data` for the pixel presented at cycle k, and `valid` matches `activevideo` delayed 2 clk.
- **Mid-frame change.** Set wpixel=4 and show=0 at line 200. The rest of the frame keeps 3× scale and draws. The next frame has no `pixel_on`, and `rom_addr` uses the 4× mapping.
- **Clipping and degenerate scale.**
  - x_scr=600, w=1: hits span columns 600..639 only, addr 0..39 per row.
  - wpixel=0: behaves as 1.
  - x_scr=1000: zero hits for the frame.
- **Reset mid-frame.** Assert `rst_n`=0 at (300,200) for 5 clk.
  - Outputs are 0 immediately.
  - After release, `pixel_on` stays 0 until the next (0,0), then the frame draws normally.

Source files
------------

// File: rtl/heart_render.sv
// Heart sprite raster stage: maps scan coordinates to heart ROM addresses using
// incremental scale counters, with sprite parameters latched once per frame.
module heart_render #(
    parameter int WIDTH_ROM  = 100,
    parameter int HEIGHT_ROM = 92,
    parameter int ADDR_W     = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        x_px,
    input  logic [9:0]        y_px,
    input  logic              activevideo,
    input  logic [9:0]        x_scr,
    input  logic [9:0]        y_scr,
    input  logic [3:0]        wpixel,
    input  logic [3:0]        hpixel,
    input  logic              show,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic              pixel_on,
    output logic              valid
);

    localparam int CW = $clog2(WIDTH_ROM);
    localparam int RW = $clog2(HEIGHT_ROM);
    localparam logic [CW-1:0]     COL_LAST = CW'(WIDTH_ROM - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(HEIGHT_ROM - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH_ROM);

    logic [9:0]        r_xs_l, r_ys_l;
    logic [3:0]        r_w_l, r_h_l;
    logic              r_show_l;
    logic              r_in_x, r_in_y;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [3:0]        r_subx, r_suby;
    logic [ADDR_W-1:0] r_rowbase, r_rom_addr;
    logic              r_av_d1, r_av_d2, r_hit_d1, r_hit_d2, r_show_d1, r_show_d2;

    logic              w_latch, w_line_end, w_y_arm, w_x_start, w_in_range, w_hit;
    logic [9:0]        w_xs, w_ys;
    logic [3:0]        w_w, w_h, w_subx;
    logic              w_show, w_in_x, w_in_y;
    logic [CW-1:0]     w_col;
    logic [ADDR_W-1:0] w_rowbase;

    // Pixel (0,0) sees the freshly latched parameters, so bypass the latches then.
    assign w_latch    = activevideo && (x_px == 10'd0) && (y_px == 10'd0);
    assign w_xs       = w_latch ? x_scr : r_xs_l;
    assign w_ys       = w_latch ? y_scr : r_ys_l;
    assign w_w        = w_latch ? ((wpixel == 4'd0) ? 4'd1 : wpixel) : r_w_l;
    assign w_h        = w_latch ? ((hpixel == 4'd0) ? 4'd1 : hpixel) : r_h_l;
    assign w_show     = w_latch ? show : r_show_l;
    assign w_line_end = r_av_d1 && !activevideo;
    assign w_y_arm    = ({1'b0, y_px} + 11'd1) == {1'b0, r_ys_l};

    assign w_x_start  = activevideo && (x_px == w_xs);
    assign w_in_x     = w_x_start || r_in_x;
    assign w_col      = w_x_start ? {CW{1'b0}} : r_col;
    assign w_subx     = w_x_start ? 4'd0 : r_subx;
    assign w_in_y     = w_latch ? (y_scr == 10'd0) : r_in_y;
    assign w_rowbase  = w_latch ? {ADDR_W{1'b0}} : r_rowbase;
    assign w_in_range = (w_xs < 10'd640) && (w_ys < 10'd480);
    assign w_hit      = activevideo && w_in_x && w_in_y && w_in_range;

    // Per-frame parameter latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xs_l   <= 10'd0;
            r_ys_l   <= 10'd0;
            r_w_l    <= 4'd1;
            r_h_l    <= 4'd1;
            r_show_l <= 1'b0;
        end else if (w_latch) begin
            r_xs_l   <= w_xs;
            r_ys_l   <= w_ys;
            r_w_l    <= w_w;
            r_h_l    <= w_h;
            r_show_l <= w_show;
        end
    end

    // Horizontal column / sub-pixel counters, stepped on active cycles only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_x <= 1'b0;
            r_col  <= {CW{1'b0}};
            r_subx <= 4'd0;
        end else if (activevideo) begin
            if (w_in_x) begin
                if (w_subx == (w_w - 4'd1)) begin
                    r_subx <= 4'd0;
                    if (w_col == COL_LAST) begin
                        r_in_x <= 1'b0;
                        r_col  <= w_col;
                    end else begin
                        r_in_x <= 1'b1;
                        r_col  <= w_col + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    r_in_x <= 1'b1;
                    r_subx <= w_subx + 4'd1;
                    r_col  <= w_col;
                end
            end
        end else if (w_line_end) begin
            r_in_x <= 1'b0;
        end
    end

    // Vertical row counters; a new frame latch also drops any sprite left over from the last frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_y    <= 1'b0;
            r_row     <= {RW{1'b0}};
            r_suby    <= 4'd0;
            r_rowbase <= {ADDR_W{1'b0}};
        end else if (w_latch) begin
            r_in_y    <= (y_scr == 10'd0);
            r_row     <= {RW{1'b0}};
            r_suby    <= 4'd0;
            r_rowbase <= {ADDR_W{1'b0}};
        end else if (w_line_end) begin
            if (w_y_arm) begin
                r_in_y    <= 1'b1;
                r_row     <= {RW{1'b0}};
                r_suby    <= 4'd0;
                r_rowbase <= {ADDR_W{1'b0}};
            end else if (r_in_y) begin
                if (r_suby == (r_h_l - 4'd1)) begin
                    r_suby    <= 4'd0;
                    r_rowbase <= r_rowbase + ROW_STEP;
                    if (r_row == ROW_LAST) begin
                        r_in_y <= 1'b0;
                    end else begin
                        r_row <= r_row + {{(RW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    r_suby <= r_suby + 4'd1;
                end
            end
        end
    end

    // ROM address register and two-stage alignment pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= {ADDR_W{1'b0}};
            r_av_d1    <= 1'b0;
            r_av_d2    <= 1'b0;
            r_hit_d1   <= 1'b0;
            r_hit_d2   <= 1'b0;
            r_show_d1  <= 1'b0;
            r_show_d2  <= 1'b0;
        end else begin
            if (w_hit) begin
                r_rom_addr <= w_rowbase + ADDR_W'(w_col);
            end
            r_av_d1   <= activevideo;
            r_av_d2   <= r_av_d1;
            r_hit_d1  <= w_hit;
            r_hit_d2  <= r_hit_d1;
            r_show_d1 <= w_show;
            r_show_d2 <= r_show_d1;
        end
    end

    assign rom_addr = r_rom_addr;
    assign valid    = r_av_d2;
    assign pixel_on = r_hit_d2 && r_show_d2 && rom_data;

endmodule

// File: tb/tb_heart_render.sv
// Scoreboard bench for heart_render: a geometric reference model predicts hit,
// address and pixel per presented coordinate; outputs are checked 1-2 cycles later.
module tb_heart_render;

    localparam int WR = 100;
    localparam int HR = 92;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x_px, y_px, x_scr, y_scr;
    logic        activevideo, show, rom_data, pixel_on, valid;
    logic [3:0]  wpixel, hpixel;
    logic [13:0] rom_addr;

    heart_render #(.WIDTH_ROM(WR), .HEIGHT_ROM(HR), .ADDR_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .x_px(x_px), .y_px(y_px), .activevideo(activevideo),
        .x_scr(x_scr), .y_scr(y_scr), .wpixel(wpixel), .hpixel(hpixel), .show(show),
        .rom_addr(rom_addr), .rom_data(rom_data), .pixel_on(pixel_on), .valid(valid)
    );

    always #5 clk = ~clk;

    // ROM model: synchronous read, bit = addr[0].
    always_ff @(posedge clk) rom_data <= rom_addr[0];

    typedef struct { bit av; bit hit; int addr; bit pon; } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int m_xs, m_ys, m_w, m_h, m_last;
    bit m_show, m_armed;
    bit full[480];
    int chg_y = -1, chg_w = 0, rst_y = -1, rst_x = 0;
    bit chg_show = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (scan x=%0d y=%0d)", tag, got, exp, x_px, y_px);
    endtask

    task automatic prefill();
        exp_t z;
        z.av = 1'b0; z.hit = 1'b0; z.addr = 0; z.pon = 1'b0;
        q.delete();
        q.push_back(z);
        q.push_back(z);
        m_armed = 1'b0; m_show = 1'b0; m_last = 0;
    endtask

    task automatic step(input int x, input int y, input bit av);
        exp_t e, o;
        x_px = 10'(x); y_px = 10'(y); activevideo = av;
        if (av && x == 0 && y == 0) begin
            m_xs = int'(x_scr); m_ys = int'(y_scr);
            m_w = (wpixel == 4'd0) ? 1 : int'(wpixel);
            m_h = (hpixel == 4'd0) ? 1 : int'(hpixel);
            m_show = show; m_armed = 1'b1;
        end
        e.av  = av;
        e.hit = av && m_armed && (m_xs < 640) && (m_ys < 480) &&
                (x >= m_xs) && (x < m_xs + WR * m_w) && (y >= m_ys) && (y < m_ys + HR * m_h);
        if (e.hit) m_last = ((y - m_ys) / m_h) * WR + (x - m_xs) / m_w;
        e.addr = m_last;
        e.pon  = e.hit && m_show && m_last[0];
        q.push_back(e);
        @(negedge clk);
        if (q.size() == 3) begin
            o = q.pop_front();
            chk("valid", valid, o.av);
            chk("pixel_on", pixel_on, o.pon);
        end
        if (q.size() == 2) chk("rom_addr", rom_addr, q[0].addr);
        @(posedge clk); #1;
    endtask

    task automatic mid_reset(input int x, input int y);
        x_px = 10'(x); y_px = 10'(y); activevideo = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pixel_on", pixel_on, 0);
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_rom_addr", rom_addr, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prefill();
    endtask

    task automatic do_line(input int y);
        int xe;
        xe = full[y] ? 639 : 0;
        if (y == chg_y) begin
            wpixel = 4'(chg_w);
            show   = chg_show;
        end
        for (int x = 0; x <= xe; x++) begin
            if (y == rst_y && x == rst_x) mid_reset(x, y);
            step(x, y, 1'b1);
        end
        step(xe + 1, y, 1'b0);
        step(xe + 2, y, 1'b0);
    endtask

    task automatic frame(input int xs, input int ys, input int w, input int h, input bit sh);
        x_scr = 10'(xs); y_scr = 10'(ys); wpixel = 4'(w); hpixel = 4'(h); show = sh;
        for (int y = 0; y < 480; y++) do_line(y);
        step(0, 480, 1'b0);
        step(0, 480, 1'b0);
        foreach (full[i]) full[i] = 1'b0;
        chg_y = -1;
        rst_y = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        x_px = 10'd0; y_px = 10'd0; activevideo = 1'b0;
        x_scr = 10'd0; y_scr = 10'd0; wpixel = 4'd0; hpixel = 4'd0; show = 1'b0;
        foreach (full[i]) full[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_pixel_on", pixel_on, 0);
        chk("reset_valid", valid, 0);
        rst_n = 1'b1;
        prefill();

        // Basic 3x scan; wpixel/show change at line 200 must not affect this frame.
        full[102] = 1'b1; full[105] = 1'b1; full[250] = 1'b1; full[377] = 1'b1; full[378] = 1'b1;
        chg_y = 200; chg_w = 4; chg_show = 1'b0;
        frame(170, 102, 3, 3, 1'b1);

        // Next frame picks up 4x width and hidden sprite.
        full[102] = 1'b1; full[150] = 1'b1;
        frame(170, 102, 4, 3, 1'b0);

        // Right-edge clipping at 1x.
        full[10] = 1'b1; full[50] = 1'b1;
        frame(600, 10, 1, 1, 1'b1);

        // Zero scale behaves as 1, sprite armed directly from the frame latch.
        full[0] = 1'b1; full[1] = 1'b1; full[91] = 1'b1; full[92] = 1'b1;
        frame(5, 0, 0, 0, 1'b1);

        // Off-screen column; rows reach past line 479.
        full[470] = 1'b1; full[479] = 1'b1;
        frame(1000, 470, 1, 3, 1'b1);

        // Reset in the middle of the sprite.
        full[50] = 1'b1; full[150] = 1'b1; full[200] = 1'b1; full[201] = 1'b1;
        rst_y = 200; rst_x = 300;
        frame(170, 102, 3, 3, 1'b1);

        // Recovery frame draws normally.
        full[102] = 1'b1; full[200] = 1'b1; full[377] = 1'b1;
        frame(170, 102, 3, 3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
